// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle MIPS control sequencer with a shared, timed-out memory port.
// Define CTRL_RETIRE_CNT_EN to build the retired-instruction counter.
module multicycle_ctrl_fsm #(
   parameter logic [5:0] HALT_OPCODE  = 6'h3F,
   parameter int         MEM_WAIT_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        RegRead,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegDst,
   output logic        Branch,
   output logic        IorD,
   output logic        MemToReg,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  PCSrc,
   output logic        halted,
   output logic        err,
   output logic [3:0]  state,
   output logic [31:0] instr_retired
);
   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC = 4'd2, S_MEM = 4'd3, S_WB = 4'd4,
      S_BRANCH = 4'd5, S_JUMP = 4'd6, S_HALT = 4'd7, S_ERROR = 4'd8
   } state_t;
   typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JR} cls_t;
   localparam int CW = $clog2(MEM_WAIT_MAX) + 1;
   state_t         st, st_n;
   cls_t           cls, cls_d;
   logic [CW-1:0]  cnt;
   logic           waiting, timeout, taken;
   assign cls_d = (opcode == 6'h00) ? ((funct == 6'h08) ? C_JR : C_R) :
                  (opcode == 6'h02 || opcode == 6'h03) ? C_J :
                  (opcode == 6'h04) ? C_BEQ :
                  (opcode == 6'h05) ? C_BNE :
                  (opcode == 6'h23) ? C_LW :
                  (opcode == 6'h28 || opcode == 6'h29 || opcode == 6'h2B) ? C_SW : C_I;
   assign waiting = (st == S_FETCH || st == S_MEM) && !mem_ready;
   assign timeout = waiting && cnt == CW'(MEM_WAIT_MAX - 1);
   assign taken   = (cls == C_BEQ && zero) || (cls == C_BNE && !zero);
   assign state   = st;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st  <= S_FETCH;
         cls <= C_R;
         cnt <= '0;
      end else begin
         st  <= st_n;
         cls <= (st == S_DECODE) ? cls_d : cls;
         cnt <= (st_n != st) ? '0 : waiting ? cnt + 1'b1 : cnt;
      end
   end
   always_comb begin
      st_n = st;
      case (st)
         S_FETCH:  st_n = mem_ready ? S_DECODE : timeout ? S_ERROR : S_FETCH;
         S_DECODE: st_n = (cls_d == C_J || cls_d == C_JR) ? S_JUMP :
                          (cls_d == C_BEQ || cls_d == C_BNE) ? S_BRANCH :
                          (cls_d != C_R && opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
         S_EXEC:   st_n = (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
         S_MEM:    st_n = mem_ready ? ((cls == C_LW) ? S_WB : S_FETCH) : timeout ? S_ERROR : S_MEM;
         S_WB, S_BRANCH, S_JUMP: st_n = S_FETCH;
         default:  st_n = st;
      endcase
   end
   // Enables are forced low while reset is held so an aborted access stops at once.
   always_comb begin
      RegRead  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegDst   = 1'b0;
      Branch   = 1'b0;
      IorD     = 1'b0;
      MemToReg = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      halted   = 1'b0;
      err      = 1'b0;
      if (!reset) begin
         case (st)
            S_FETCH: begin
               MemRead = 1'b1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: RegRead = (opcode != 6'h0F);
            S_MEM: begin
               IorD     = 1'b1;
               MemRead  = (cls == C_LW);
               MemWrite = (cls == C_SW);
            end
            S_WB: begin
               RegWrite = 1'b1;
               RegDst   = (cls == C_R);
               MemToReg = (cls == C_LW);
            end
            S_BRANCH: begin
               Branch  = 1'b1;
               PCWrite = taken;
               PCSrc   = 2'b01;
            end
            S_JUMP: begin
               PCWrite = 1'b1;
               PCSrc   = (cls == C_JR) ? 2'b11 : 2'b10;
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: err = 1'b1;
            default: ;
         endcase
      end
   end
`ifdef CTRL_RETIRE_CNT_EN
   logic [31:0] ret;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ret <= '0;
      else if (st != S_FETCH && st_n == S_FETCH) ret <= ret + 32'd1;
   end
   assign instr_retired = ret;
`else
   assign instr_retired = 32'd0;
`endif
endmodule
